// File: rtl/divclk_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
package divclk_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DIV_MIN   = 2;

    function automatic logic div_is_legal(input logic [31:0] n);
        return n >= DIV_MIN;
    endfunction

    // ceil(n/2); the extra bit keeps n = 2^32-1 from wrapping.
    function automatic logic [31:0] div_high_len(input logic [31:0] n);
        logic [32:0] sum;
        sum = {1'b0, n} + 33'd1;
        return sum[32:1];
    endfunction

endpackage

// File: rtl/divclk_period_ctr.sv
// Period counter and registered clk_out/tick generation for the active divisor.
module divclk_period_ctr
    import divclk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] div_n_i,
    output logic             boundary_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phase_last;
    logic [CNT_W-1:0] high_len;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    assign high_len   = CNT_W'(div_high_len(32'(div_n_i)));
    assign phase_last = div_n_i - CNT_W'(1);

    // An idle divider is always at a boundary, so pending divisors apply immediately.
    assign boundary_o = !run_q || (cnt_q == phase_last);

    always_comb begin
        cnt_d     = '0;
        run_d     = 1'b0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (enable_i) begin
            run_d = 1'b1;
            if (run_q && (cnt_q < phase_last)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            clk_out_d = cnt_d < high_len;
            tick_d    = cnt_d == '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            run_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/divclk_prog.sv
// Runtime-programmable clock divider with load/ack divisor handshake.
// Define DIVCLK_PROG_PERIOD_CNT_EN to add the period_cnt tick counter output.
module divclk_prog
    import divclk_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick
`ifdef DIVCLK_PROG_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             boundary;
    logic             load_legal;
    logic             apply;

    assign load_legal = div_is_legal(32'(div_value));
    // Uses the registered pending flag, so a load in the boundary cycle waits a period.
    assign apply      = pend_q && boundary;

    always_comb begin
        div_act_d  = div_act_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        ack_d      = apply;
        err_d      = div_load && !load_legal;
        if (apply) begin
            div_act_d = pend_val_q;
            pend_d    = 1'b0;
        end
        if (div_load && load_legal) begin
            pend_val_d = div_value;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_act_q  <= CNT_W'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            div_act_q  <= div_act_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    divclk_period_ctr #(
        .CNT_W (CNT_W)
    ) u_period_ctr (
        .clk_i      (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .div_n_i    (div_act_q),
        .boundary_o (boundary),
        .clk_out_o  (clk_out),
        .tick_o     (tick)
    );

    assign div_ack = ack_q;
    assign div_err = err_q;

`ifdef DIVCLK_PROG_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || ack_q) begin
            period_cnt_q <= '0;
        end else if (tick) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_divclk_prog.sv
// Directed self-checking bench for divclk_prog.
module tb_divclk_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_value;
    logic        div_load;
    logic        div_ack;
    logic        div_err;
    logic        clk_out;
    logic        tick;
`ifdef DIVCLK_PROG_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divclk_prog #(
        .CNT_W       (16),
        .DEFAULT_DIV (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .div_value  (div_value),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .clk_out    (clk_out),
        .tick       (tick)
`ifdef DIVCLK_PROG_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks phases p0..p1 of a period of length n, one cycle per phase.
    task automatic check_phases(input int n, input int p0, input int p1, input bit ack0,
                                input int errp);
        int h;
        h = (n + 1) / 2;
        for (int p = p0; p <= p1; p++) begin
            chk($sformatf("clk_out n=%0d p=%0d", n, p), clk_out, p < h);
            chk($sformatf("tick n=%0d p=%0d", n, p), tick, p == 0);
            chk($sformatf("div_ack n=%0d p=%0d", n, p), div_ack, ack0 && (p == 0));
            chk($sformatf("div_err n=%0d p=%0d", n, p), div_err, p == errp);
            step();
        end
    endtask

    task automatic check_idle(input string tag, input logic ack_exp);
        chk({tag, " clk_out"}, clk_out, 1'b0);
        chk({tag, " tick"}, tick, 1'b0);
        chk({tag, " div_ack"}, div_ack, ack_exp);
        chk({tag, " div_err"}, div_err, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        div_value = '0;
        div_load  = 1'b0;
        step();
        step();
        check_idle("reset", 1'b0);
`ifdef DIVCLK_PROG_PERIOD_CNT_EN
        chk("period_cnt reset", period_cnt == 16'd0, 1'b1);
`endif

        // Default divide-by-2 after reset
        reset  = 1'b0;
        enable = 1'b1;
        check_idle("pre-enable", 1'b0);
        step();
        for (int i = 0; i < 3; i++) check_phases(2, 0, 1, 1'b0, -1);

        // Load N=5 while running; the N=2 boundary is the very next cycle
        div_load  = 1'b1;
        div_value = 16'd5;
        check_phases(2, 0, 0, 1'b0, -1);
        div_load = 1'b0;
        check_phases(2, 1, 1, 1'b0, -1);
        check_phases(5, 0, 4, 1'b1, -1);
        check_phases(5, 0, 4, 1'b0, -1);

        // Load 7 then 4 before the boundary; only 4 is applied
        div_load  = 1'b1;
        div_value = 16'd7;
        check_phases(5, 0, 0, 1'b0, -1);
        div_value = 16'd4;
        check_phases(5, 1, 1, 1'b0, -1);
        div_load = 1'b0;
        check_phases(5, 2, 4, 1'b0, -1);
        check_phases(4, 0, 3, 1'b1, -1);
        check_phases(4, 0, 3, 1'b0, -1);

        // Illegal loads 1 then 0; waveform unchanged, no ack
        div_load  = 1'b1;
        div_value = 16'd1;
        check_phases(4, 0, 0, 1'b0, -1);
        div_value = 16'd0;
        check_phases(4, 1, 1, 1'b0, 1);
        div_load = 1'b0;
        check_phases(4, 2, 3, 1'b0, 2);
        check_phases(4, 0, 3, 1'b0, -1);

        // Switch to N=6, then stop the divider
        div_load  = 1'b1;
        div_value = 16'd6;
        check_phases(4, 0, 0, 1'b0, -1);
        div_load = 1'b0;
        check_phases(4, 1, 3, 1'b0, -1);
        check_phases(6, 0, 5, 1'b1, -1);
        enable = 1'b0;
        check_phases(6, 0, 0, 1'b0, -1);
        check_idle("disabled 1", 1'b0);
        step();
        check_idle("disabled 2", 1'b0);
        step();

        // Load N=3 while disabled: ack two cycles after the load
        div_load  = 1'b1;
        div_value = 16'd3;
        check_idle("idle load", 1'b0);
        step();
        div_load = 1'b0;
        check_idle("idle load+1", 1'b0);
        step();
        check_idle("idle load+2", 1'b1);
        step();
        enable = 1'b1;
        check_idle("idle load+3", 1'b0);
        step();
        check_phases(3, 0, 2, 1'b0, -1);
        check_phases(3, 0, 2, 1'b0, -1);

        // Reset mid-high-phase with a load pending, then reset with simultaneous loads
        div_load  = 1'b1;
        div_value = 16'd9;
        check_phases(3, 0, 0, 1'b0, -1);
        reset     = 1'b1;
        div_value = 16'd1;
        chk("pre-reset clk_out high", clk_out, 1'b1);
        step();
        check_idle("reset cycle 1", 1'b0);
`ifdef DIVCLK_PROG_PERIOD_CNT_EN
        chk("period_cnt after reset", period_cnt == 16'd0, 1'b1);
`endif
        div_value = 16'd5;
        step();
        reset    = 1'b0;
        div_load = 1'b0;
        check_idle("reset cycle 2", 1'b0);
        step();
        // Back to DEFAULT_DIV with no stale ack
        check_phases(2, 0, 1, 1'b0, -1);
        check_phases(2, 0, 1, 1'b0, -1);
        check_phases(2, 0, 1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
